// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - state encoding and ns-to-cycle timing helpers for the WS2812 chain driver
package ws2812_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW,
    S_LATCH
  } state_t;

  localparam int unsigned DEF_CLK_HZ    = 48000000;
  localparam int unsigned DEF_T0H_NS    = 400;
  localparam int unsigned DEF_T1H_NS    = 800;
  localparam int unsigned DEF_TBIT_NS   = 1250;
  localparam int unsigned DEF_TRESET_NS = 50000;

  // Truncating conversion; clock is taken in whole MHz first.
  function automatic int unsigned ns_to_cyc(input int unsigned ns, input int unsigned clk_hz);
    return ns * (clk_hz / 1000000) / 1000;
  endfunction

  localparam int unsigned DEF_T0H_CYC    = ns_to_cyc(DEF_T0H_NS, DEF_CLK_HZ);
  localparam int unsigned DEF_T1H_CYC    = ns_to_cyc(DEF_T1H_NS, DEF_CLK_HZ);
  localparam int unsigned DEF_TBIT_CYC   = ns_to_cyc(DEF_TBIT_NS, DEF_CLK_HZ);
  localparam int unsigned DEF_TRESET_CYC = ns_to_cyc(DEF_TRESET_NS, DEF_CLK_HZ);

endpackage

// File: rtl/ws2812_bit_encoder.sv
// rtl/ws2812_bit_encoder.sv - NRZ bit-cell timer producing the high/low shape of one WS2812 bit
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H_CYC  = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC  = DEF_T1H_CYC,
  parameter int unsigned TBIT_CYC = DEF_TBIT_CYC,
  parameter int unsigned CW       = 12
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_bit_valid,
  input  logic i_bit_val,
  output logic o_dout,
  output logic o_high_done,
  output logic o_bit_done
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_high_len;

  assign w_high_len = i_bit_val ? CW'(T1H_CYC) : CW'(T0H_CYC);

  // Counter wraps on the last cycle of a bit so back-to-back bits stay gapless.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_bit_valid || o_bit_done) r_cnt <= '0;
    else                                     r_cnt <= r_cnt + CW'(1);
  end

  assign o_dout      = i_bit_valid && (r_cnt < w_high_len);
  assign o_high_done = i_bit_valid && (r_cnt == w_high_len - CW'(1));
  assign o_bit_done  = i_bit_valid && (r_cnt == CW'(TBIT_CYC - 1));

endmodule

// File: rtl/ws2812_chain_tx.sv
// rtl/ws2812_chain_tx.sv - frame-buffered WS2812/SK6812 chain transmitter with latch gap
module ws2812_chain_tx
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned BITS_PER_LED = 24,
  parameter int unsigned T0H_NS       = DEF_T0H_NS,
  parameter int unsigned T1H_NS       = DEF_T1H_NS,
  parameter int unsigned TBIT_NS      = DEF_TBIT_NS,
  parameter int unsigned TRESET_NS    = DEF_TRESET_NS,
  localparam int unsigned AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr_en,
  input  logic [AW-1:0]           i_wr_addr,
  input  logic [BITS_PER_LED-1:0] i_wr_data,
  input  logic                    i_start,
  output logic                    o_bsy,
  output logic                    o_done,
  output logic                    o_dout
);

  localparam int unsigned T0H_CYC    = ns_to_cyc(T0H_NS, CLK_HZ);
  localparam int unsigned T1H_CYC    = ns_to_cyc(T1H_NS, CLK_HZ);
  localparam int unsigned TBIT_CYC   = ns_to_cyc(TBIT_NS, CLK_HZ);
  localparam int unsigned TRESET_CYC = ns_to_cyc(TRESET_NS, CLK_HZ);
  localparam int unsigned CMAX       = (TBIT_CYC > TRESET_CYC) ? TBIT_CYC : TRESET_CYC;
  localparam int unsigned CW         = $clog2(CMAX + 1);
  localparam int unsigned BW         = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam int unsigned DEPTH      = 1 << AW;

  generate
    if (T1H_CYC >= TBIT_CYC || T0H_CYC == 0) begin : g_bad_timing
      $error("ws2812_chain_tx: T1H must be shorter than the bit period and T0H non-zero");
    end
  endgenerate

  state_t                  r_state, w_next;
  logic [BITS_PER_LED-1:0] r_buf [DEPTH];
  logic [BITS_PER_LED-1:0] r_shift, r_next;
  logic [AW-1:0]           r_pix;
  logic [BW-1:0]           r_bit;
  logic [CW-1:0]           r_latch_cnt;
  logic                    r_done;
  logic                    w_bit_valid, w_enc_dout, w_high_done, w_bit_done;
  logic                    w_last_bit, w_last_pix, w_latch_end;

  assign w_bit_valid = (r_state == S_HIGH) || (r_state == S_LOW);
  assign w_last_bit  = (r_bit == '0);
  assign w_last_pix  = (r_pix == AW'(NUM_LEDS - 1));
  assign w_latch_end = (r_latch_cnt == CW'(TRESET_CYC - 1));

  // Writes are only taken while idle, so the frame is frozen once accepted.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (r_state == S_IDLE) && (32'(i_wr_addr) < NUM_LEDS))
      r_buf[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LOAD;
      S_LOAD:  w_next = S_HIGH;
      S_HIGH:  if (w_high_done) w_next = S_LOW;
      S_LOW:   if (w_bit_done) w_next = (w_last_bit && w_last_pix) ? S_LATCH : S_HIGH;
      S_LATCH: if (w_latch_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift     <= '0;
      r_next      <= '0;
      r_pix       <= '0;
      r_bit       <= '0;
      r_latch_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_LATCH) && w_latch_end;
      case (r_state)
        S_LOAD: begin
          r_shift <= r_buf[AW'(0)];
          r_next  <= r_buf[AW'(1)];
          r_pix   <= '0;
          r_bit   <= BW'(BITS_PER_LED - 1);
        end
        S_LOW: if (w_bit_done) begin
          if (!w_last_bit) begin
            r_shift <= r_shift << 1;
            r_bit   <= r_bit - BW'(1);
          end else if (!w_last_pix) begin
            // Prefetched word swaps in on the last cycle of the bit: no gap at the pixel seam.
            r_shift <= r_next;
            r_next  <= r_buf[r_pix + AW'(2)];
            r_pix   <= r_pix + AW'(1);
            r_bit   <= BW'(BITS_PER_LED - 1);
          end
        end
        S_LATCH: r_latch_cnt <= w_latch_end ? '0 : r_latch_cnt + CW'(1);
        default: ;
      endcase
    end
  end

  ws2812_bit_encoder #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .TBIT_CYC(TBIT_CYC),
    .CW      (CW)
  ) u_enc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_bit_valid(w_bit_valid),
    .i_bit_val  (r_shift[BITS_PER_LED-1]),
    .o_dout     (w_enc_dout),
    .o_high_done(w_high_done),
    .o_bit_done (w_bit_done)
  );

  assign o_dout = w_enc_dout & ~i_rst;
  assign o_bsy  = (r_state != S_IDLE);
  assign o_done = r_done;

endmodule

// File: doc/ws2812_chain_tx.md
Name: ws2812_chain_tx

Overview:
- Parametrised WS2812/SK6812 chain driver; successor to the single-word `ws2812_tx`.
- Holds a frame buffer of NUM_LEDS pixel words, written through a simple write port.
- On `start`, streams the whole frame as one gapless NRZ bit train on `dout`, then holds the latch/reset gap before returning idle.
- Sits between the pixel-generation logic and the LED data pin on the 48 MHz domain.

Parameters:
- CLK_HZ, 48000000: system clock frequency in Hz.
- NUM_LEDS, 8: pixels in the chain, at least 1.
- BITS_PER_LED, 24: bits per pixel; 24 for GRB, 32 for GRBW (SK6812).
- T0H_NS, 400: high time of a 0 bit, in ns.
- T1H_NS, 800: high time of a 1 bit, in ns.
- TBIT_NS, 1250: total bit period, in ns.
- TRESET_NS, 50000: low latch gap after the frame, in ns.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  frame buffer write strobe.
- wr_addr  in  $clog2(NUM_LEDS) (min 1)  pixel index.
- wr_data  in  BITS_PER_LED  pixel word, sent MSB first.
- start  in  1  begin frame transmission.
- bsy  out  1  high from frame accept to end of latch gap.
- done  out  1  one-cycle pulse when bsy falls.
- dout  out  1  serial LED data line.

Behaviour:
- Cycle constants, computed at elaboration as X_CYC = X_NS*(CLK_HZ/1000000)/1000, truncated.
  - Defaults: T0H_CYC=19, T1H_CYC=38, TBIT_CYC=60, TRESET_CYC=2400.
  - Elaboration error if T1H_CYC >= TBIT_CYC or T0H_CYC == 0.
- Reset: dout=0, bsy=0, done=0, state IDLE, all counters 0. Frame buffer contents are not reset.
- Reset mid-frame: state returns to IDLE in the next cycle and dout drops to 0 immediately. The partial frame is abandoned.
- FSM states: IDLE, LOAD, HIGH, LOW, LATCH.
- IDLE:
  - start=1 moves to LOAD next cycle and sets bsy=1.
  - Buffer read address is 0.
- LOAD, exactly 1 cycle per frame:
  - Shift register takes buffer[0]; pixel index 0, bit index BITS_PER_LED-1.
  - Prefetch of buffer[1] is issued.
- HIGH:
  - dout=1 for T0H_CYC or T1H_CYC cycles, chosen by the current MSB; then go to LOW.
- LOW:
  - dout=0 for the remainder of the bit, so HIGH+LOW totals exactly TBIT_CYC cycles.
  - At the end of LOW, if bits remain, shift left and go to HIGH.
  - Else, if pixels remain, load the prefetched word, issue the next prefetch, and go to HIGH with no extra cycle.
  - Else go to LATCH.
- Bit-train continuity: the period is exactly TBIT_CYC across pixel boundaries, with no gap.
- LATCH:
  - dout=0 for TRESET_CYC cycles.
  - Then go to IDLE with bsy=0 and done=1 for one cycle.
- Latency: start accepted at edge k gives bsy=1 after k, and the first dout rise after edge k+1.
- A full frame occupies 1 + NUM_LEDS*BITS_PER_LED*TBIT_CYC + TRESET_CYC cycles of bsy.
- start while bsy=1 is ignored; no queueing.
- Writes:
  - wr_en with bsy=0 writes buffer[wr_addr] at the clock edge.
  - wr_en while bsy=1 is dropped, so frame content is stable during transmission.
  - wr_addr >= NUM_LEDS is ignored.
- Write and start in the same IDLE cycle: the write lands first, and the frame sends the new value.
- Counters:
  - Bit-time counter width is $clog2(max(TBIT_CYC, TRESET_CYC)+1).
  - Pixel index wraps never; the end is compared against NUM_LEDS-1.

Decomposition:
- Package `ws2812_pkg`:
  - state enum (IDLE, LOAD, HIGH, LOW, LATCH);
  - ns-to-cycle constant function;
  - default timing constants.
- Sub-module `ws2812_bit_encoder`:
  - inputs: clk, rst, bit_valid, bit_val;
  - outputs: dout, bit_done;
  - owns the HIGH/LOW counter.
- Top module owns the frame buffer, shift register, pixel/bit indices and the LATCH counter.

Test Plan:
- Reset then idle: hold rst=1 for 3 cycles, release -> dout=0, bsy=0, done=0; no activity for 100 cycles.
- Single frame, NUM_LEDS=2: write buffer[0]=24'hAAAAAA and buffer[1]=24'h0F00F0, pulse start.
  - dout high widths must read 38,19,38,19,... then the 24'h0F00F0 pattern.
  - Every bit period must be 60 cycles, including the pixel boundary.
  - bsy must last 1+48*60+2400 = 5281 cycles, and done must pulse once.
- GRBW mode, BITS_PER_LED=32, NUM_LEDS=1: write 32'hFFFFFFFF -> 32 pulses of 38 cycles each, then 2400 low.
- Write and start collisions:
  - wr_en to buffer[0]=0 mid-frame -> the next frame still sends the old value.
  - start pulse mid-frame -> no restart; total bsy length unchanged.
- Reset mid-frame: assert rst during bit 5 of pixel 1 -> dout=0 and bsy=0 the next cycle, no done pulse; a new start then sends the full frame.
- Same-cycle write+start in IDLE: buffer[0]=24'h800000 -> the first pulse is 38 cycles and the next 23 are 19 cycles.
